// File: rtl/ap_kernel_arbiter_if.sv
// Requester and kernel ap_ctrl_chain signals shared by ap_kernel_arbiter.
// The master modport is the arbiter side; slave is the agent/kernel side.
interface ap_kernel_arbiter_if #(
   parameter int NREQ = 3
) ();
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ack;
   logic [NREQ-1:0] req_done;
   logic [IDW-1:0]  grant_id;
   logic            k_ap_start;
   logic            k_ap_ready;
   logic            k_ap_done;
   logic            k_ap_continue;

   modport master (
      input  req_valid, k_ap_ready, k_ap_done,
      output req_ack, req_done, grant_id,
      output k_ap_start, k_ap_continue
   );

   modport slave (
      output req_valid, k_ap_ready, k_ap_done,
      input  req_ack, req_done, grant_id,
      input  k_ap_start, k_ap_continue
   );
endinterface

// File: rtl/ap_kernel_arbiter.sv
// Round-robin start arbiter for one pipelined ap_ctrl_chain kernel.
// An in-order ID FIFO routes each ap_done back to the requester that started it.
module ap_kernel_arbiter #(
   parameter int NREQ       = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                ap_clk,
   input  logic                ap_rst_n,
   ap_kernel_arbiter_if.master bus,
   input  logic                flush,
   output logic                flush_done,
   output logic [CNT_W-1:0]    txn_count,
   output logic                err_orphan
);
   localparam int IDW = $clog2(NREQ);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int OW  = PW + 1;
   localparam logic [OW-1:0] FULL = OW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDW-1:0]   grant_q, grant_d;
   logic [IDW-1:0]   rr_q, rr_d;
   logic [IDW-1:0]   fifo_q [FIFO_DEPTH];
   logic [IDW-1:0]   fifo_d [FIFO_DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [OW-1:0]    occ_q, occ_d;
   logic [CNT_W-1:0] txn_q, txn_d;
   logic             orphan_q, orphan_d;

   logic            push, pop, empty;
   logic [IDW-1:0]  grant_nxt;
   logic [NREQ-1:0] b2b_req;
   logic [IDW:0]    pick_idle, pick_b2b;

   // Returns {found, index} of the first set bit at or after start, wrapping.
   function automatic logic [IDW:0] rr_pick(
      input logic [NREQ-1:0] req,
      input logic [IDW-1:0]  start
   );
      logic [IDW:0] r;
      int idx;
      r = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(start) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) r = {1'b1, IDW'(idx)};
      end
      return r;
   endfunction

   assign empty     = (occ_q == '0);
   assign push      = (state_q == S_ISSUE) & bus.k_ap_ready;
   assign pop       = bus.k_ap_done & ~empty;
   assign occ_d     = occ_q + OW'(push) - OW'(pop);
   assign grant_nxt = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

   // The acked requester's valid still belongs to the start being accepted.
   assign b2b_req   = bus.req_valid & ~(NREQ'(1) << grant_q);
   assign pick_idle = rr_pick(bus.req_valid, rr_q);
   assign pick_b2b  = rr_pick(b2b_req, grant_nxt);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               state_d = S_FLUSH;
            end else if (pick_idle[IDW] && ((occ_q < FULL) || pop)) begin
               grant_d = pick_idle[IDW-1:0];
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (push) begin
               rr_d = grant_nxt;
               if (!flush && pick_b2b[IDW] && (occ_d < FULL)) begin
                  grant_d = pick_b2b[IDW-1:0];
               end else begin
                  state_d = flush ? S_FLUSH : S_IDLE;
               end
            end
         end
         S_FLUSH: begin
            if (!flush) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      fifo_d   = fifo_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      txn_d    = txn_q;
      orphan_d = orphan_q;
      if (push) begin
         fifo_d[wptr_q] = grant_q;
         wptr_d         = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
         if (txn_q != '1) txn_d = txn_q + 1'b1;
      end
      if (bus.k_ap_done && empty) orphan_d = 1'b1;
   end

   always_comb begin
      bus.req_ack  = '0;
      bus.req_done = '0;
      if (push) bus.req_ack[grant_q] = 1'b1;
      if (pop)  bus.req_done[fifo_q[rptr_q]] = 1'b1;
   end

   assign bus.grant_id      = grant_q;
   assign bus.k_ap_start    = (state_q == S_ISSUE);
   assign bus.k_ap_continue = ~empty;
   assign flush_done        = flush & (state_q != S_ISSUE) & (occ_d == '0);
   assign txn_count         = txn_q;
   assign err_orphan        = orphan_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         rr_q     <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         occ_q    <= '0;
         txn_q    <= '0;
         orphan_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         occ_q    <= occ_d;
         txn_q    <= txn_d;
         orphan_q <= orphan_d;
         fifo_q   <= fifo_d;
      end
   end
endmodule
